div32x16_seq: RTL and testbench

- Iterative radix-2 restoring divider: the inverse datapath of the MAC16 multiplier tile; recovers quotient/remainder from products and accumulations.
- Sits next to the MAC16 wrapper in the DSP slice library and consumes its 32-bit O bus as the dividend.
- One quotient bit per cycle; START/BUSY/DONE handshake.
- Signedness controls mirror the multiplier's ASGND/BSGND.

---
 rtl/dsp_div_pkg.sv | 9 +
 rtl/div_step.sv | 19 +
 rtl/div32x16_seq.sv | 119 +++++++++++
 tb/tb_div32x16_seq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/dsp_div_pkg.sv
// dsp_div_pkg: shared FSM state, counter width and result constants for the sequential divider
package dsp_div_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
  localparam int DIV_DW = 32;
  localparam int DIV_VW = 16;
  localparam int CNT_W = $clog2(DIV_DW + 1);
  localparam logic [DIV_DW-1:0] Q_ONES = '1;
  localparam logic [DIV_VW-1:0] R_ZERO = '0;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step; p_i/bit_i shifted, divisor d_i trial-subtracted -> p_o, quotient bit q_o
module div_step #(
  parameter int VW = 16
) (
  input  logic [VW:0]   p_i,
  input  logic          bit_i,
  input  logic [VW-1:0] d_i,
  output logic [VW:0]   p_o,
  output logic          q_o
);
  logic [VW+1:0] sh;
  logic [VW+1:0] df;
  always_comb begin
    sh  = {p_i, bit_i};
    df  = sh - {2'b00, d_i};
    q_o = ~df[VW+1];
    p_o = q_o ? df[VW:0] : sh[VW:0];
  end
endmodule

// File: rtl/div32x16_seq.sv
// div32x16_seq: radix-2 restoring divider; CLK/RSTN, START/HLD/ASGND/BSGND/A/B in, BUSY/DONE/Q/R/DZ/OVF out
module div32x16_seq
  import dsp_div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          START,
  input  logic          HLD,
  input  logic          ASGND,
  input  logic          BSGND,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic          BUSY,
  output logic          DONE,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          DZ,
  output logic          OVF
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d, q_q, q_d;
  logic [VW-1:0] b_q, b_d, r_q, r_d;
  logic [VW:0] p_q, p_d, p_nx;
  logic sa_q, sa_d, sb_q, sb_d, sg_q, sg_d, dz_q, dz_d, ovf_q, ovf_d;
  logic sa_in, sb_in, qb, bz;
  assign sa_in = ASGND & A[DW-1];
  assign sb_in = BSGND & B[VW-1];
  assign bz    = (b_q == '0);
  div_step #(.VW(VW)) u_step (
    .p_i  (p_q),
    .bit_i(a_q[DW-1]),
    .d_i  (b_q),
    .p_o  (p_nx),
    .q_o  (qb)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sg_d    = sg_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: if (START) begin
        state_d = S_CALC;
        sa_d    = sa_in;
        sb_d    = sb_in;
        sg_d    = ASGND & BSGND;
        b_d     = sb_in ? -B : B;
        // a zero divisor keeps the raw dividend so its low half can be returned as R
        a_d     = (B == '0) ? A : (sa_in ? -A : A);
        p_d     = '0;
        cnt_d   = (B == '0) ? '0 : CNT_W'(DW);
      end
      S_CALC: if (!HLD) begin
        if (cnt_q == '0) state_d = S_FIX;
        else begin
          p_d   = p_nx;
          a_d   = {a_q[DW-2:0], qb};
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        dz_d    = bz;
        q_d     = bz ? Q_ONES[DW-1:0] : ((sa_q ^ sb_q) ? -a_q : a_q);
        r_d     = bz ? a_q[VW-1:0] : (sa_q ? -p_q[VW-1:0] : p_q[VW-1:0]);
        // only -2^(DW-1) / -1 yields a positive magnitude with the top bit set
        ovf_d   = ~bz & sg_q & ~(sa_q ^ sb_q) & a_q[DW-1];
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sg_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= R_ZERO;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sg_q    <= sg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end
  assign BUSY = (state_q == S_CALC) || (state_q == S_FIX);
  assign DONE = (state_q == S_DONE);
  assign Q    = q_q;
  assign R    = r_q;
  assign DZ   = dz_q;
  assign OVF  = ovf_q;
endmodule

// File: tb/tb_div32x16_seq.sv
// tb_div32x16_seq: scoreboard bench with directed divide vectors for div32x16_seq
module tb_div32x16_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, hld = 1'b0, asgnd = 1'b0, bsgnd = 1'b0;
  logic [31:0] a = '0;
  logic [15:0] b = '0;
  logic busy, done, dz, ovf;
  logic [31:0] q;
  logic [15:0] r;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic dz;
    logic ovf;
    int lat;
    int st;
  } exp_t;
  exp_t sb[$];
  div32x16_seq dut (
    .CLK(clk), .RSTN(rst_n), .START(start), .HLD(hld), .ASGND(asgnd), .BSGND(bsgnd),
    .A(a), .B(b), .BUSY(busy), .DONE(done), .Q(q), .R(r), .DZ(dz), .OVF(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done act=1 exp=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("r", {16'h0, r}, {16'h0, e.r});
        chk("dz", {31'h0, dz}, {31'h0, e.dz});
        chk("ovf", {31'h0, ovf}, {31'h0, e.ovf});
        chk("latency", cyc - e.st, e.lat);
      end
    end
  end
  task automatic issue(input logic [31:0] ai, input logic [15:0] bi, input logic as, input logic bs,
                       input logic [31:0] eq, input logic [15:0] er, input logic edz, input logic eovf,
                       input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    a = ai; b = bi; asgnd = as; bsgnd = bs; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e = '{q: eq, r: er, dz: edz, ovf: eovf, lat: lat, st: cyc};
    if (push) sb.push_back(e);
  endtask
  task automatic wait_done(input bit chk_busy);
    int n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      if (chk_busy) chk("busy", {31'h0, busy}, 1);
      n++;
      @(negedge clk);
    end
    if (!done) chk("timeout", 0, 1);
    else chk("busy_at_done", {31'h0, busy}, 0);
  endtask
  initial begin
    #1;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_q", q, 0);
    chk("rst_flags", {30'h0, dz, ovf}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(32'h0001_0000, 16'h0003, 0, 0, 32'h0000_5555, 16'h0001, 0, 0, 34, 1);
    wait_done(1);
    issue(32'hFFFF_FFF9, 16'h0002, 1, 1, 32'hFFFF_FFFD, 16'hFFFF, 0, 0, 34, 1);
    wait_done(1);
    issue(32'h1234_5678, 16'h0000, 0, 0, 32'hFFFF_FFFF, 16'h5678, 1, 0, 2, 1);
    wait_done(1);
    issue(32'h8000_0000, 16'hFFFF, 1, 1, 32'h8000_0000, 16'h0000, 0, 1, 34, 1);
    wait_done(1);
    issue(32'hFFFF_FFF9, 16'h0002, 0, 0, 32'h7FFF_FFFC, 16'h0001, 0, 0, 34, 1);
    wait_done(0);
    issue(32'hFFFF_FF9C, 16'hFFF9, 1, 1, 32'h0000_000E, 16'hFFFE, 0, 0, 34, 1);
    wait_done(0);
    issue(32'h0000_0064, 16'hFFF9, 1, 1, 32'hFFFF_FFF2, 16'h0002, 0, 0, 34, 1);
    wait_done(0);
    issue(32'h0000_0007, 16'hFFFE, 0, 1, 32'hFFFF_FFFD, 16'h0001, 0, 0, 34, 1);
    wait_done(0);
    issue(32'hFFFF_FFFF, 16'h00FF, 0, 0, 32'h0101_0101, 16'h0000, 0, 0, 39, 1);
    repeat (10) @(negedge clk);
    hld = 1'b1;
    repeat (5) @(negedge clk);
    hld = 1'b0;
    wait_done(1);
    issue(32'd1000, 16'd10, 0, 0, 32'd100, 16'd0, 0, 0, 34, 1);
    repeat (3) @(negedge clk);
    a = 32'd5; b = 16'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (45) @(negedge clk);
    chk("idle_after_ignored_start", {31'h0, busy}, 0);
    issue(32'h1234_5678, 16'h0003, 0, 0, 32'h0, 16'h0, 0, 0, 34, 0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy}, 0);
    chk("arst_done", {31'h0, done}, 0);
    chk("arst_q", q, 0);
    chk("arst_r", {16'h0, r}, 0);
    chk("arst_flags", {30'h0, dz, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd100, 16'd7, 0, 0, 32'd14, 16'd2, 0, 0, 34, 1);
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
